// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
//
// Purpose: packs field-level RV32I instruction records into the 32-bit
// encodings consumed by the decode stage and writes them into instruction
// memory at consecutive word addresses, one record per valid/ready handshake.
// Used by the boot path and by testbenches to preload programs.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   start, base_addr     begin a load session at base_addr (IDLE/DONE only)
//   in_valid, in_ready   record handshake
//   in_op, in_alusel     operation class and R-type ALU select
//   in_rd/rs1/rs2        register indices
//   in_imm               signed byte offset / immediate (21-bit two's compl.)
//   in_last              final record of the session
//   imem_we, imem_ready  write strobe (held until accepted) / memory accept
//   imem_addr, imem_wdata write byte address and encoded instruction
//   busy, done           session in progress / session finished
//   err_illegal          sticky: an illegal record was consumed
//   err_overflow         sticky: a record was dropped at MAX_WORDS
//   count                instructions written this session
// ---------------------------------------------------------------------------
module instr_encoder_loader #(
  parameter int MAX_WORDS = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [2:0]        in_alusel,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [20:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_overflow,
  output logic [15:0]       count
);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t            state_reg, state_next;
  logic              pend_reg, pend_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [15:0]       count_reg, count_next;
  logic              err_ill_reg, err_ill_next;
  logic              err_ovf_reg, err_ovf_next;

  // ---------------------------------------------------------------------------
  // Encoder: combinational pack of the presented record plus legality.
  // ---------------------------------------------------------------------------
  logic [31:0] enc_word;
  logic        enc_legal;
  logic [6:0]  r_funct7;
  logic [2:0]  r_funct3;
  logic        fits12;
  logic        fits13;

  // A 21-bit value fits in N signed bits when all bits from N-1 upward agree.
  assign fits12 = (&in_imm[20:11]) | ~(|in_imm[20:11]);
  assign fits13 = (&in_imm[20:12]) | ~(|in_imm[20:12]);

  always_comb begin
    r_funct7 = 7'b0000000;
    r_funct3 = 3'b000;
    case (in_alusel)
      3'b000: r_funct3 = 3'b000;                                // add
      3'b001: r_funct3 = 3'b001;                                // sll
      3'b010: begin r_funct3 = 3'b000; r_funct7 = 7'b0100000; end // sub
      3'b011: begin r_funct3 = 3'b101; r_funct7 = 7'b0100000; end // sra
      3'b100: r_funct3 = 3'b100;                                // xor
      3'b101: r_funct3 = 3'b101;                                // srl
      3'b110: r_funct3 = 3'b110;                                // or
      default: r_funct3 = 3'b111;                               // and
    endcase
  end

  always_comb begin
    enc_word  = 32'd0;
    enc_legal = 1'b1;
    case (in_op)
      3'd0: enc_word = {r_funct7, in_rs2, in_rs1, r_funct3, in_rd, OPC_R};
      3'd1: begin
        enc_word  = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_I};
        enc_legal = fits12 && (in_alusel == 3'b000);
      end
      3'd2: begin
        enc_word  = {in_imm[11:0], in_rs1, 3'b010, in_rd, OPC_LOAD};
        enc_legal = fits12;
      end
      3'd3: begin
        enc_word  = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OPC_STORE};
        enc_legal = fits12;
      end
      3'd4: begin
        enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                     in_imm[4:1], in_imm[11], OPC_BRANCH};
        // 13-bit signed range with bit 0 clear gives -4096..4094.
        enc_legal = fits13 && !in_imm[0];
      end
      3'd5: begin
        enc_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                     in_rd, OPC_JAL};
        enc_legal = !in_imm[0];
      end
      default: enc_legal = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  logic        ready_c;
  logic        accept;
  logic        wr_done;
  logic [16:0] committed;
  logic        full;

  assign ready_c = (state_reg == LOAD) && (!pend_reg || imem_ready);
  assign accept  = in_valid && ready_c;
  assign wr_done = pend_reg && imem_ready;

  // Words already written plus the one still pending: a write that completes
  // this cycle is already counted through pend_reg.
  assign committed = {1'b0, count_reg} + {16'd0, pend_reg};
  assign full      = (committed == 17'(MAX_WORDS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      pend_reg    <= 1'b0;
      ptr_reg     <= '0;
      wdata_reg   <= 32'd0;
      count_reg   <= 16'd0;
      err_ill_reg <= 1'b0;
      err_ovf_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pend_reg    <= pend_next;
      ptr_reg     <= ptr_next;
      wdata_reg   <= wdata_next;
      count_reg   <= count_next;
      err_ill_reg <= err_ill_next;
      err_ovf_reg <= err_ovf_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pend_next    = pend_reg;
    ptr_next     = ptr_reg;
    wdata_next   = wdata_reg;
    count_next   = count_reg;
    err_ill_next = err_ill_reg;
    err_ovf_next = err_ovf_reg;

    // The pointer always addresses the pending (or next) write, so it only
    // moves when memory takes a word.
    if (wr_done) begin
      pend_next  = 1'b0;
      ptr_next   = ptr_reg + ADDR_W'(4);
      count_next = count_reg + 16'd1;
    end

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next   = LOAD;
          ptr_next     = base_addr;
          count_next   = 16'd0;
          err_ill_next = 1'b0;
          err_ovf_next = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          if (!enc_legal) begin
            err_ill_next = 1'b1;
          end else if (full) begin
            err_ovf_next = 1'b1;
            state_next   = DRAIN;
          end else begin
            pend_next  = 1'b1;
            wdata_next = enc_word;
          end
          if (in_last) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!pend_reg || imem_ready) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready     = ready_c;
  assign imem_we      = pend_reg;
  assign imem_addr    = ptr_reg;
  assign imem_wdata   = wdata_reg;
  assign busy         = (state_reg == LOAD) || (state_reg == DRAIN);
  assign done         = (state_reg == DONE);
  assign err_illegal  = err_ill_reg;
  assign err_overflow = err_ovf_reg;
  assign count        = count_reg;

endmodule
